// File: rtl/pipelined_adder_tree_if.sv
// Handshake/data bundle for pipelined_adder_tree.
//   master: producer of operand vectors and consumer of sums (the bench/upstream)
//   slave : the adder tree itself
// Signals: in_valid/in_ready + inputs/in_mask/sat_en on the input side,
//          out_valid/out_ready + sum/sum_ovf on the output side.
interface pipelined_adder_tree_if #(
    parameter int N_INPUTS  = 9,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [IN_WIDTH-1:0]  inputs [N_INPUTS];
    logic [N_INPUTS-1:0]         in_mask;
    logic                        sat_en;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] sum;
    logic                        sum_ovf;

    modport master (
        output in_valid, inputs, in_mask, sat_en, out_ready,
        input  in_ready, out_valid, sum, sum_ovf
    );

    modport slave (
        input  in_valid, inputs, in_mask, sat_en, out_ready,
        output in_ready, out_valid, sum, sum_ovf
    );
endinterface

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed reduction of N_INPUTS masked operands.
// One register bank per pairwise reduction stage; the last bank is the output
// register (sum, sum_ovf, out_valid). Latency STAGES, one vector per cycle,
// whole pipeline freezes while the output is valid but not accepted.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (clears valid bits and outputs)
//   bus  - pipelined_adder_tree_if.slave (valid/ready in, valid/ready out)

// Masks one lane and sign-extends it to the full reduction width.
module pipelined_adder_tree_lane #(
    parameter int IN_WIDTH = 16,
    parameter int SUM_W    = 20
) (
    input  logic                       en,
    input  logic signed [IN_WIDTH-1:0] d,
    output logic signed [SUM_W-1:0]    q
);
    assign q = en ? {{(SUM_W-IN_WIDTH){d[IN_WIDTH-1]}}, d} : '0;
endmodule

module pipelined_adder_tree #(
    parameter int N_INPUTS  = 9,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipelined_adder_tree_if.slave  bus
);
    localparam int STAGES = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int SUM_W  = IN_WIDTH + STAGES;

    // Representable range of the result, expressed at full precision.
    localparam logic signed [SUM_W-1:0] MAXV =
        {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MINV = ~MAXV;
    localparam logic signed [OUT_WIDTH-1:0] OMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OMIN = ~OMAX;

    logic                    stall;
    logic [STAGES:0]         vld_pipe;   // [0] = accept this cycle, [STAGES] = out_valid
    logic [STAGES-1:0]       sat_pipe;   // mode travelling with each slot
    logic signed [SUM_W-1:0] ext [N_INPUTS];

    // Only registered state and out_ready feed in_ready.
    assign stall        = vld_pipe[STAGES] & ~bus.out_ready;
    assign bus.in_ready = ~stall;
    assign bus.out_valid = vld_pipe[STAGES];
    assign vld_pipe[0]  = bus.in_valid & ~stall;
    assign sat_pipe[0]  = bus.sat_en;

    for (genvar i = 0; i < N_INPUTS; i++) begin : lane
        pipelined_adder_tree_lane #(.IN_WIDTH(IN_WIDTH), .SUM_W(SUM_W)) u_lane (
            .en (bus.in_mask[i]),
            .d  (bus.inputs[i]),
            .q  (ext[i])
        );
    end

    // Stage s reduces ceil(N/2^(s-1)) elements into ceil(N/2^s). Slots past
    // the live element count are tied to zero and never read downstream.
    for (genvar s = 1; s <= STAGES; s++) begin : stg
        localparam int CIN = (N_INPUTS + (1 << (s-1)) - 1) >> (s-1);
        logic signed [SUM_W-1:0] prv [N_INPUTS];
        logic signed [SUM_W-1:0] red [N_INPUTS];
        logic signed [SUM_W-1:0] q   [N_INPUTS];

        if (s == 1) begin : g_first
            assign prv = ext;
        end else begin : g_chain
            assign prv = stg[s-1].q;
        end

        for (genvar k = 0; k < N_INPUTS; k++) begin : el
            if (2*k+1 < CIN) begin : g_add
                assign red[k] = prv[2*k] + prv[2*k+1];
            end else if (2*k < CIN) begin : g_pass
                assign red[k] = prv[2*k];
            end else begin : g_zero
                assign red[k] = '0;
            end
        end

        // The last stage's bank is the output register below.
        if (s < STAGES) begin : g_reg
            always_ff @(posedge clk) begin
                if (!stall) q <= red;
            end
        end else begin : g_out
            assign q = red;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe[STAGES:1] <= '0;
        else if (!stall) vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    if (STAGES > 1) begin : g_sat
        always_ff @(posedge clk) begin
            if (!stall) sat_pipe[STAGES-1:1] <= sat_pipe[STAGES-2:0];
        end
    end

    logic signed [SUM_W-1:0]     full;
    logic                        ovf;
    logic signed [OUT_WIDTH-1:0] conv;

    assign full = stg[STAGES].q[0];

    always_comb begin
        ovf  = (full > MAXV) || (full < MINV);
        conv = full[OUT_WIDTH-1:0];
        if (ovf && sat_pipe[STAGES-1]) conv = full[SUM_W-1] ? OMIN : OMAX;
    end

    // Loaded only by valid slots so bubbles leave the last result in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sum     <= '0;
            bus.sum_ovf <= 1'b0;
        end else if (!stall && vld_pipe[STAGES-1]) begin
            bus.sum     <= conv;
            bus.sum_ovf <= ovf;
        end
    end
endmodule

// File: tb/tb_pipelined_adder_tree.sv
module tb_pipelined_adder_tree;
    localparam int N  = 9;
    localparam int IW = 16;
    localparam int OW = 16;
    localparam int ST = 4;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic srst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   sweep_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_adder_tree_if #(.N_INPUTS(N), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();
    pipelined_adder_tree #(.N_INPUTS(N), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct { longint s; bit o; } exp_t;

    // Reference conversion: plain integer range test, clamp or two's-complement wrap.
    function automatic void conv(input longint s, input int ow, input bit sat,
                                 output longint r, output bit o);
        longint span, hi, lo;
        span = longint'(1) <<< ow;
        hi = span / 2 - 1;
        lo = -(span / 2);
        o = (s > hi) || (s < lo);
        if (o && sat) r = (s > hi) ? hi : lo;
        else begin
            r = s & (span - 1);
            if (r > hi) r = r - span;
        end
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- main scoreboard (N=9) ----------------
    exp_t   mq[$];
    exp_t   me, mpush;
    longint ms;
    bit     held = 0;
    longint hsum;
    bit     hovf;

    always @(posedge clk or posedge rst) begin
        if (rst) mq.delete();
        else if (bus.in_valid && bus.in_ready) begin
            ms = 0;
            for (int i = 0; i < N; i++) if (bus.in_mask[i]) ms += longint'(bus.inputs[i]);
            conv(ms, OW, bus.sat_en, mpush.s, mpush.o);
            mq.push_back(mpush);
        end
    end

    always @(negedge clk) begin
        if (rst) held = 0;
        else begin
            if (held) begin
                chk("hold_valid", longint'(bus.out_valid), 1);
                chk("hold_sum", longint'(bus.sum), hsum);
                chk("hold_ovf", longint'(bus.sum_ovf), longint'(hovf));
            end
            held = 0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    checks++;
                    if (mq.size() == 0) begin
                        errors++;
                        $display("FAIL main_spurious: got out_valid=1 with no pending transaction, expected out_valid=0");
                    end else begin
                        me = mq.pop_front();
                        chk("main_sum", longint'(bus.sum), me.s);
                        chk("main_ovf", longint'(bus.sum_ovf), longint'(me.o));
                    end
                end else begin
                    held = 1;
                    hsum = longint'(bus.sum);
                    hovf = bus.sum_ovf;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_all(input int v);
        for (int i = 0; i < N; i++) bus.inputs[i] = IW'(v);
    endtask

    task automatic issue();
        int n = 0;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // One isolated transaction: checks exact latency and the literal result.
    task automatic run_one(input string name, input longint es, input longint eo);
        issue();
        chk({name, "_early"}, longint'(bus.out_valid), 0);
        repeat (ST - 2) begin
            @(posedge clk); #1;
            chk({name, "_early"}, longint'(bus.out_valid), 0);
        end
        @(posedge clk); #1;
        chk({name, "_valid"}, longint'(bus.out_valid), 1);
        chk({name, "_sum"}, longint'(bus.sum), es);
        chk({name, "_ovf"}, longint'(bus.sum_ovf), eo);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        int seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.sat_en    = 1'b1;
        bus.in_mask   = '1;
        set_all(0);
        rst  = 1'b1;
        srst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_sum", longint'(bus.sum), 0);
        chk("rst_ovf", longint'(bus.sum_ovf), 0);
        chk("rst_in_ready", longint'(bus.in_ready), 1);
        rst  = 1'b0;
        srst = 1'b0;
        @(posedge clk); #1;

        set_all(1); bus.sat_en = 1'b1;
        run_one("ones", 9, 0);
        set_all(32767);
        run_one("pos_sat", 32767, 1);
        bus.sat_en = 1'b0;
        run_one("pos_wrap", 32759, 1);
        set_all(-32768); bus.sat_en = 1'b1;
        run_one("neg_sat", -32768, 1);
        bus.sat_en = 1'b0;
        run_one("neg_wrap", -32768, 1);
        for (int i = 0; i < N; i++) bus.inputs[i] = IW'(i + 1);
        bus.in_mask = 9'b000000101; bus.sat_en = 1'b1;
        run_one("masked", 4, 0);
        set_all(0);
        for (int i = 0; i < 4; i++) bus.inputs[i] = 16'sd20000;
        bus.in_mask = '1; bus.sat_en = 1'b0;
        run_one("part_wrap", 14464, 1);
        bus.sat_en = 1'b1;
        run_one("part_sat", 32767, 1);
        set_all(-5); bus.in_mask = 9'b100000001;
        run_one("neg_small", -10, 0);

        // Back-to-back with a 3-cycle downstream stall.
        bus.in_mask = '1; bus.sat_en = 1'b1;
        set_all(1); bus.in_valid = 1'b1;
        @(posedge clk); #1; set_all(2);
        @(posedge clk); #1; set_all(3);
        @(posedge clk); #1; bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("b2b_first_valid", longint'(bus.out_valid), 1);
        chk("b2b_first_sum", longint'(bus.sum), 9);
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_in_ready", longint'(bus.in_ready), 0);
            chk("stall_valid", longint'(bus.out_valid), 1);
            chk("stall_sum", longint'(bus.sum), 9);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("b2b_second_valid", longint'(bus.out_valid), 1);
        chk("b2b_second_sum", longint'(bus.sum), 18);
        @(posedge clk); #1;
        chk("b2b_third_valid", longint'(bus.out_valid), 1);
        chk("b2b_third_sum", longint'(bus.sum), 27);
        @(posedge clk); #1;
        chk("b2b_drained", longint'(bus.out_valid), 0);

        // Reset with three transactions in flight.
        set_all(1); bus.in_valid = 1'b1;
        @(posedge clk); #1; set_all(2);
        @(posedge clk); #1; set_all(3);
        @(posedge clk); #1; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", longint'(bus.out_valid), 1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", longint'(bus.out_valid), 0);
        chk("midrst_sum", longint'(bus.sum), 0);
        chk("midrst_ovf", longint'(bus.sum_ovf), 0);
        chk("midrst_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        chk("post_rst_silence", seen, 0);
        set_all(2);
        run_one("after_rst", 18, 0);

        n = 0;
        while (sweep_done < 5 && n < 2000) begin @(posedge clk); n++; end
        chk("sweep_complete", sweep_done, 5);
        chk("main_drain", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- parameter sweep, random traffic, out_ready held high ----------------
    for (genvar g = 0; g < 5; g++) begin : sw
        localparam int SN  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 8 : 64;
        localparam int SST = (SN > 1) ? $clog2(SN) : 1;

        pipelined_adder_tree_if #(.N_INPUTS(SN), .IN_WIDTH(8), .OUT_WIDTH(8)) sb ();
        pipelined_adder_tree #(.N_INPUTS(SN), .IN_WIDTH(8), .OUT_WIDTH(8)) sdut (
            .clk (clk),
            .rst (srst),
            .bus (sb.slave)
        );

        exp_t   sq[$];
        int     sc[$];
        exp_t   spush, sexp;
        longint ss;
        int     sacc;

        always @(posedge clk) begin
            if (!srst && sb.in_valid && sb.in_ready) begin
                ss = 0;
                for (int i = 0; i < SN; i++) if (sb.in_mask[i]) ss += longint'(sb.inputs[i]);
                conv(ss, 8, sb.sat_en, spush.s, spush.o);
                sq.push_back(spush);
                sc.push_back(cyc);
            end
        end

        always @(negedge clk) begin
            if (!srst) begin
                chk("sw_in_ready", longint'(sb.in_ready), 1);
                if (sb.out_valid) begin
                    checks++;
                    if (sq.size() == 0) begin
                        errors++;
                        $display("FAIL sw_spurious N=%0d: got out_valid=1 with no pending transaction, expected out_valid=0", SN);
                    end else begin
                        sexp = sq.pop_front();
                        sacc = sc.pop_front();
                        chk("sw_sum", longint'(sb.sum), sexp.s);
                        chk("sw_ovf", longint'(sb.sum_ovf), longint'(sexp.o));
                        chk("sw_latency", cyc - sacc, SST);
                    end
                end
            end
        end

        initial begin
            sb.in_valid  = 1'b0;
            sb.out_ready = 1'b1;
            sb.sat_en    = 1'b0;
            sb.in_mask   = '0;
            for (int i = 0; i < SN; i++) sb.inputs[i] = '0;
            @(negedge srst);
            repeat (300) begin
                @(posedge clk); #1;
                sb.in_valid = ($urandom_range(0, 4) != 0);
                for (int i = 0; i < SN; i++) sb.inputs[i] = 8'($urandom);
                sb.in_mask = SN'({$urandom, $urandom});
                sb.sat_en  = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            sb.in_valid = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            chk("sw_drain", sq.size(), 0);
            sweep_done++;
        end
    end
endmodule
